// File: rtl/lifo8x8_if.sv
// Push/pop handshake bundle for the 8-entry LIFO.
// The stack owns the slave side; its user owns the master side.
interface lifo8x8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic             i_push;
    logic             i_pop;
    logic [WIDTH-1:0] o_s0;
    logic [WIDTH-1:0] o_s1;
    logic             o_empty;
    logic             o_full;

    modport master (
        output i_data,
        output i_push,
        output i_pop,
        input  o_s0,
        input  o_s1,
        input  o_empty,
        input  o_full
    );

    modport slave (
        input  i_data,
        input  i_push,
        input  i_pop,
        output o_s0,
        output o_s1,
        output o_empty,
        output o_full
    );
endinterface

// File: rtl/lifo8x8.sv
// 8-deep push-down stack as a register shift array.
// Top two entries are exposed straight from registers.
module lifo8x8 #(
    parameter int WIDTH = 8
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    lifo8x8_if.slave bus
);
    localparam int DEPTH = 8;

    // Declaration values match reset so the block runs with i_rst_n tied high
    logic [WIDTH-1:0] r_e [DEPTH] = '{default: '0};
    logic [3:0]       r_cnt       = 4'd0;

    logic w_at_empty;
    logic w_at_full;

    assign w_at_empty = (r_cnt == 4'd0);
    assign w_at_full  = (r_cnt == 4'd8);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_e[k] <= '0;
            end
            r_cnt <= 4'd0;
        end else begin
            case ({bus.i_push, bus.i_pop})
                2'b10: begin
                    r_e[0] <= bus.i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_e[k] <= r_e[k-1];
                    end
                    if (!w_at_full) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                2'b01: begin
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        r_e[k] <= r_e[k+1];
                    end
                    r_e[DEPTH-1] <= '0;
                    if (!w_at_empty) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                2'b11: begin
                    // Replacing the top of an empty stack is a push
                    r_e[0] <= bus.i_data;
                    if (w_at_empty) begin
                        r_cnt <= 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_s0    = r_e[0];
    assign bus.o_s1    = r_e[1];
    assign bus.o_empty = w_at_empty;
    assign bus.o_full  = w_at_full;
endmodule

// File: tb/tb_lifo8x8.sv
// Bench for lifo8x8: directed scenarios plus random traffic
// checked against a queue model of the stack.
module tb_lifo8x8;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    lifo8x8_if #(.WIDTH(8)) u_if ();

    lifo8x8 #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    function automatic logic [7:0] m_s0();
        return (q.size() > 0) ? q[0] : 8'd0;
    endfunction

    function automatic logic [7:0] m_s1();
        return (q.size() > 1) ? q[1] : 8'd0;
    endfunction

    task automatic drive(input logic p, input logic o, input logic [7:0] d);
        @(negedge clk);
        u_if.i_push = p;
        u_if.i_pop  = o;
        u_if.i_data = d;
    endtask

    task automatic apply_edge();
        @(posedge clk);
        case ({u_if.i_push, u_if.i_pop})
            2'b10: begin
                q.push_front(u_if.i_data);
                if (q.size() > 8) void'(q.pop_back());
            end
            2'b01: if (q.size() > 0) void'(q.pop_front());
            2'b11: begin
                if (q.size() == 0) q.push_front(u_if.i_data);
                else q[0] = u_if.i_data;
            end
            default: ;
        endcase
        #1;
        u_if.i_push = 1'b0;
        u_if.i_pop  = 1'b0;
    endtask

    task automatic op(input logic p, input logic o, input logic [7:0] d);
        drive(p, o, d);
        apply_edge();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (u_if.o_s0 !== 8'd0 || u_if.o_s1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got s0=%0d s1=%0d exp 0 0", u_if.o_s0, u_if.o_s1);
        end
        checks++;
        if (u_if.o_empty !== 1'b1 || u_if.o_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got e=%b f=%b exp 1 0", u_if.o_empty, u_if.o_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_push_pop();
        op(1, 0, 8'd13);
        checks++;
        if (u_if.o_s0 !== 8'd13 || u_if.o_empty !== 1'b0) begin
            errors++;
            $display("FAIL push13 got s0=%0d e=%b exp 13 0", u_if.o_s0, u_if.o_empty);
        end
        op(1, 0, 8'd21);
        checks++;
        if (u_if.o_s0 !== 8'd21 || u_if.o_s1 !== 8'd13) begin
            errors++;
            $display("FAIL push21 got s0=%0d s1=%0d exp 21 13", u_if.o_s0, u_if.o_s1);
        end
        op(0, 1, 8'd0);
        checks++;
        if (u_if.o_s0 !== 8'd13) begin
            errors++;
            $display("FAIL pop13 got s0=%0d exp 13", u_if.o_s0);
        end
    endtask

    task automatic test_replace();
        op(1, 1, 8'd34);
        checks++;
        if (u_if.o_s0 !== 8'd34 || u_if.o_s1 !== 8'd0 || u_if.o_empty !== 1'b0) begin
            errors++;
            $display("FAIL replace34 got s0=%0d s1=%0d e=%b exp 34 0 0",
                     u_if.o_s0, u_if.o_s1, u_if.o_empty);
        end
        op(1, 0, 8'd55);
        checks++;
        if (u_if.o_s0 !== 8'd55 || u_if.o_s1 !== 8'd34) begin
            errors++;
            $display("FAIL push55 got s0=%0d s1=%0d exp 55 34", u_if.o_s0, u_if.o_s1);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 8'd89);
        checks++;
        if (u_if.o_s0 !== 8'd55 || u_if.o_s1 !== 8'd34) begin
            errors++;
            $display("FAIL b2b_pre_push got s0=%0d s1=%0d exp 55 34", u_if.o_s0, u_if.o_s1);
        end
        apply_edge();
        drive(0, 1, 8'd0);
        checks++;
        if (u_if.o_s0 !== 8'd89 || u_if.o_s1 !== 8'd55) begin
            errors++;
            $display("FAIL b2b_pre_pop got s0=%0d s1=%0d exp 89 55", u_if.o_s0, u_if.o_s1);
        end
        apply_edge();
        drive(0, 1, 8'd0);
        checks++;
        if (u_if.o_s0 !== 8'd55 || u_if.o_s1 !== 8'd34) begin
            errors++;
            $display("FAIL b2b_pre_pop2 got s0=%0d s1=%0d exp 55 34", u_if.o_s0, u_if.o_s1);
        end
        apply_edge();
        checks++;
        if (u_if.o_s0 !== 8'd34) begin
            errors++;
            $display("FAIL b2b_final got s0=%0d exp 34", u_if.o_s0);
        end
        op(0, 1, 8'd0);
        checks++;
        if (u_if.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got e=%b exp 1", u_if.o_empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            op(1, 0, 8'(i));
            if (i == 7) begin
                checks++;
                if (u_if.o_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at7 got %b exp 0", u_if.o_full);
                end
            end
            if (i >= 8) begin
                checks++;
                if (u_if.o_full !== 1'b1 || u_if.o_s0 !== 8'(i)) begin
                    errors++;
                    $display("FAIL full_push%0d got f=%b s0=%0d exp 1 %0d",
                             i, u_if.o_full, u_if.o_s0, i);
                end
            end
        end
        for (int i = 9; i >= 2; i--) begin
            checks++;
            if (u_if.o_s0 !== 8'(i)) begin
                errors++;
                $display("FAIL drain_s0 got %0d exp %0d", u_if.o_s0, i);
            end
            op(0, 1, 8'd0);
        end
        checks++;
        if (u_if.o_empty !== 1'b1 || u_if.o_s0 !== 8'd0) begin
            errors++;
            $display("FAIL drain_end got e=%b s0=%0d exp 1 0", u_if.o_empty, u_if.o_s0);
        end
    endtask

    task automatic test_underflow();
        op(0, 1, 8'd0);
        checks++;
        if (u_if.o_s0 !== 8'd0 || u_if.o_s1 !== 8'd0 || u_if.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow got s0=%0d s1=%0d e=%b exp 0 0 1",
                     u_if.o_s0, u_if.o_s1, u_if.o_empty);
        end
        op(1, 1, 8'd7);
        checks++;
        if (u_if.o_s0 !== 8'd7 || u_if.o_empty !== 1'b0 || u_if.o_full !== 1'b0) begin
            errors++;
            $display("FAIL replace_empty got s0=%0d e=%b f=%b exp 7 0 0",
                     u_if.o_s0, u_if.o_empty, u_if.o_full);
        end
        op(0, 1, 8'd0);
        checks++;
        if (u_if.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL replace_empty_cnt got e=%b exp 1", u_if.o_empty);
        end
    endtask

    task automatic test_async_reset();
        op(1, 0, 8'd11);
        op(1, 0, 8'd22);
        op(1, 0, 8'd33);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (u_if.o_s0 !== 8'd0 || u_if.o_s1 !== 8'd0 ||
            u_if.o_empty !== 1'b1 || u_if.o_full !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got s0=%0d s1=%0d e=%b f=%b exp 0 0 1 0",
                     u_if.o_s0, u_if.o_s1, u_if.o_empty, u_if.o_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op(1, 0, 8'd5);
        checks++;
        if (u_if.o_s0 !== 8'd5 || u_if.o_s1 !== 8'd0) begin
            errors++;
            $display("FAIL post_rst got s0=%0d s1=%0d exp 5 0", u_if.o_s0, u_if.o_s1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 5) op(1, 0, d);
            else if (r < 8) op(0, 1, d);
            else if (r == 8) op(1, 1, d);
            else op(0, 0, d);
            checks++;
            if (u_if.o_s0 !== m_s0() || u_if.o_s1 !== m_s1() ||
                u_if.o_empty !== (q.size() == 0) || u_if.o_full !== (q.size() == 8)) begin
                errors++;
                $display("FAIL rand%0d got s0=%0d s1=%0d e=%b f=%b exp %0d %0d %b %b",
                         n, u_if.o_s0, u_if.o_s1, u_if.o_empty, u_if.o_full,
                         m_s0(), m_s1(), q.size() == 0, q.size() == 8);
            end
        end
    endtask

    initial begin
        u_if.i_push = 1'b0;
        u_if.i_pop  = 1'b0;
        u_if.i_data = 8'd0;
        test_reset();
        test_push_pop();
        test_replace();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lifo8x8.md
Name: lifo8x8

Overview:
- Fixed-depth (8-entry) push-down stack of WIDTH-bit words, built as a register shift array.
- The top two entries are always visible combinationally, for use by stack-machine datapaths (operand stacks, return stacks).
- Push, pop, and replace-top (push and pop together) each complete in a single clock.
- Occupancy flags are provided for overflow and underflow detection. Overflow and underflow are non-fatal.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1..64).

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  WIDTH  word to push.
- i_push  input  1  push request, sampled on rising edge of i_clk.
- i_pop  input  1  pop request, sampled on rising edge of i_clk.
- o_s0  output  WIDTH  top of stack (entry 0), registered, no read latency.
- o_s1  output  WIDTH  next on stack (entry 1), registered, no read latency.
- o_empty  output  1  high when occupancy count == 0.
- o_full  output  1  high when occupancy count == 8.

Behaviour:
- Storage: entries e0 (top) .. e7 (bottom), each WIDTH bits.
  - o_s0 = e0, o_s1 = e1, driven directly from registers.
  - Occupancy counter cnt is 4 bits, range 0..8.
- Reset (i_rst_n low, asynchronous, no clock needed):
  - all entries = 0; cnt = 0.
  - o_s0 = o_s1 = 0; o_empty = 1; o_full = 0.
  - Reset mid-operation discards all contents immediately.
  - Release is synchronous to i_clk: the first edge after deassertion acts normally.
- Power-up/configuration initial values equal the reset values, so the block works with i_rst_n tied high.
- Each rising edge with i_rst_n high, decode {i_push, i_pop}:
  - 00 idle: no change.
  - 10 push:
    - e0 <= i_data; e(k) <= e(k-1) for k = 1..7; old e7 is discarded.
    - cnt <= min(cnt+1, 8).
  - 01 pop:
    - e(k) <= e(k+1) for k = 0..6; e7 <= 0.
    - cnt <= max(cnt-1, 0).
  - 11 replace top:
    - e0 <= i_data; e1..e7 unchanged; cnt unchanged.
    - When cnt == 0, replace-top acts as push: cnt <= 1.
- Outputs reflect the new state one edge after the request.
  - During the request cycle they show the pre-operation values.
  - The caller may therefore read s0/s1 and issue push/pop in the same cycle.
- Overflow: push at cnt == 8 is accepted. The bottom entry is lost, cnt stays 8, o_full stays high. No error flag.
- Underflow: pop at cnt == 0 shifts in zeros. Contents stay all-zero, cnt stays 0.
- Entries beyond cnt are don't-care for function but are deterministic per the shift rules above.
- Flags are combinational decodes of cnt. No glitches reach outputs beyond register-output timing.
- No X propagation: every register has a defined reset and initial value.

Test Plan:
- Reset, then push 13 -> next cycle o_s0 = 13, o_empty = 0. Push 21 -> o_s0 = 21, o_s1 = 13. Pop -> o_s0 = 13.
- Stack [13]: pop+push 34 in same cycle -> o_s0 = 34, o_s1 = 0, cnt = 1. Then push 55 -> o_s0 = 55, o_s1 = 34.
- Back-to-back, with o_s0/o_s1 checked on the same edge as each request:
  - push 89 while o_s0 = 55 and o_s1 = 34 -> o_s0 = 89, o_s1 = 55.
  - pop while o_s0 = 89 and o_s1 = 55 -> o_s0 = 55, o_s1 = 34.
  - pop -> o_s0 = 34.
- Push 1..9 consecutively:
  - after the 8th push, o_full = 1;
  - after the 9th push, o_s0 = 9 and o_full = 1;
  - 8 pops then yield 9, 8, ..., 2 on o_s0, and value 1 is lost;
  - afterwards o_empty = 1 and o_s0 = 0.
- Empty stack: pop -> o_s0 = o_s1 = 0, o_empty stays 1. Pop+push 7 on empty -> o_s0 = 7, cnt = 1.
- Push 3 values, assert i_rst_n low between clock edges -> outputs 0 and o_empty = 1 immediately. After release, push 5 -> o_s0 = 5, o_s1 = 0.
